sst_sequencer: RTL

//  Save-state initiator: drives the mapper SST bus (sst.act/addr/we_reg/dato, reads mai.sst_di) to

---
 rtl/sst_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sst_sequencer.sv
// ============================================================================
// sst_sequencer : save-state initiator; walks the mapper SST port to dump
// every register into a host buffer or restore them from it.  Rev 1.0
// ============================================================================
`default_nettype none

module sst_sequencer #(
  parameter int NUM_REGS   = 128,
  parameter int IDX_ADDR   = 127,
  parameter int VERIFY_IDX = 1
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       start,
  input  logic       dir,
  input  logic       cpu_m3,
  input  logic [7:0] sst_di,
  input  logic [7:0] buf_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_wdata,
  output logic       buf_we
);

  localparam int         LAST_I   = NUM_REGS - 1;
  localparam logic [7:0] LAST_IDX = LAST_I[7:0];
  localparam logic [7:0] IDX_A    = IDX_ADDR[7:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ADDR = 3'd1,
    S_CAP  = 3'd2,
    C_RD   = 3'd3,
    C_CMP  = 3'd4,
    R_RD   = 3'd5,
    R_WR   = 3'd6,
    FIN    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sst_act_q, sst_act_d;
  logic [7:0] sst_addr_q, sst_addr_d;
  logic       sst_we_reg_q, sst_we_reg_d;
  logic [7:0] sst_dato_q, sst_dato_d;
  logic [7:0] buf_addr_q, buf_addr_d;
  logic [7:0] buf_wdata_q, buf_wdata_d;
  logic       buf_we_q, buf_we_d;
  logic       last_idx;

  assign last_idx = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = 8'd0;
          err_d = 1'b0;
          if (!dir)               state_d = S_ADDR;
          else if (VERIFY_IDX != 0) state_d = C_RD;
          else                    state_d = R_RD;
        end
      end
      S_ADDR: state_d = S_CAP;
      S_CAP: begin
        if (last_idx) state_d = FIN;
        else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_ADDR;
        end
      end
      C_RD: state_d = C_CMP;
      C_CMP: begin
        if (buf_rdata == sst_di) state_d = R_RD;
        else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      R_RD: begin
        // The map index register is read-only: step over it without a write.
        if (idx_q != IDX_A)  state_d = R_WR;
        else if (last_idx)   state_d = FIN;
        else                 idx_d   = idx_q + 8'd1;
      end
      R_WR: begin
        if (cpu_m3) begin
          if (last_idx) state_d = FIN;
          else begin
            idx_d   = idx_q + 8'd1;
            state_d = R_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state requires.
    busy_d       = (state_d != IDLE);
    sst_act_d    = (state_d != IDLE);
    done_d       = (state_d == FIN);
    buf_we_d     = (state_d == S_CAP);
    sst_we_reg_d = (state_d == R_WR);
    buf_wdata_d  = (state_d == S_CAP) ? sst_di : 8'd0;

    case (state_d)
      S_ADDR, S_CAP, R_RD, R_WR: sst_addr_d = idx_d;
      C_RD, C_CMP:               sst_addr_d = IDX_A;
      default:                   sst_addr_d = 8'd0;
    endcase

    case (state_d)
      S_CAP, R_RD, R_WR: buf_addr_d = idx_d;
      C_RD, C_CMP:       buf_addr_d = IDX_A;
      default:           buf_addr_d = 8'd0;
    endcase

    if (state_d != R_WR)      sst_dato_d = 8'd0;
    else if (state_q == R_RD) sst_dato_d = buf_rdata;
    else                      sst_dato_d = sst_dato_q;
  end

  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sst_act_q    <= 1'b0;
      sst_addr_q   <= 8'd0;
      sst_we_reg_q <= 1'b0;
      sst_dato_q   <= 8'd0;
      buf_addr_q   <= 8'd0;
      buf_wdata_q  <= 8'd0;
      buf_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sst_act_q    <= sst_act_d;
      sst_addr_q   <= sst_addr_d;
      sst_we_reg_q <= sst_we_reg_d;
      sst_dato_q   <= sst_dato_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      buf_we_q     <= buf_we_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sst_act    = sst_act_q;
  assign sst_addr   = sst_addr_q;
  assign sst_we_reg = sst_we_reg_q;
  assign sst_dato   = sst_dato_q;
  assign buf_addr   = buf_addr_q;
  assign buf_wdata  = buf_wdata_q;
  assign buf_we     = buf_we_q;

endmodule

`default_nettype wire
